// File: rtl/siso_pkg.sv
// siso_pkg: shared FSM states, PRBS7 taps and byte width for the SISO PRBS checker
package siso_pkg;
  typedef enum logic [1:0] {IDLE, SEED, CHECK} state_e;
  localparam int PRBS_W = 7;
  localparam int TAP_A  = 6;
  localparam int TAP_B  = 5;
  localparam int BYTE_W = 8;
  localparam int PH_W   = $clog2(BYTE_W);
endpackage

// File: rtl/prbs7_lfsr.sv
// prbs7_lfsr: 7-bit PRBS register, loads external bits while seeding or free-runs on its own feedback
module prbs7_lfsr
  import siso_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              run,
  input  logic              din,
  output logic [PRBS_W-1:0] nxt,
  output logic              fb
);
  logic [PRBS_W-1:0] lfsr_q, lfsr_d;
  always_comb begin
    fb     = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
    lfsr_d = load ? {lfsr_q[PRBS_W-2:0], din} : run ? {lfsr_q[PRBS_W-2:0], fb} : lfsr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= '0;
    else        lfsr_q <= lfsr_d;
  assign nxt = lfsr_d;
endmodule

// File: rtl/siso_prbs_checker.sv
// siso_prbs_checker: self-synchronising PRBS7 checker with lock FSM, saturating error count and byte assembly
module siso_prbs_checker
  import siso_pkg::*;
#(
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             lock,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       byte_out,
  output logic             byte_valid
);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  state_e            state_q, state_d;
  logic [2:0]        seed_cnt_q, seed_cnt_d;
  logic [3:0]        miss_q, miss_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [BYTE_W-1:0] sh_q, sh_d, byte_q, byte_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              bv_q, bv_d, lock_q, lock_d;
  logic [PRBS_W-1:0] lfsr_nxt;
  logic              fb, act, seeding, checking, miss, seed_done, lost;
  assign act       = ena && din_valid && state_q != IDLE;
  assign seeding   = act && state_q == SEED;
  assign checking  = act && state_q == CHECK;
  assign miss      = checking && din != fb;
  assign seed_done = seeding && seed_cnt_q == 3'(PRBS_W-1);
  assign lost      = miss && miss_q + 4'd1 == 4'(LOSS_THRESH);
  prbs7_lfsr u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (seeding),
    .run  (checking),
    .din  (din),
    .nxt  (lfsr_nxt),
    .fb   (fb)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // an all-zero seed would lock the PRBS generator at zero, so keep seeding
  always_comb begin
    state_d = state_q;
    if (!ena) state_d = IDLE;
    else if (state_q == IDLE) state_d = SEED;
    else if (seed_done && lfsr_nxt != '0) state_d = CHECK;
    else if (lost) state_d = SEED;
  end
  always_comb begin
    seed_cnt_d = (!ena || seed_done || lost) ? '0 : seeding ? seed_cnt_q + 3'd1 : seed_cnt_q;
    miss_d     = (!ena || lost) ? '0 : miss ? miss_q + 4'd1 : checking ? '0 : miss_q;
    err_d      = clear ? '0 : (miss && err_q != ERR_MAX) ? err_q + ERR_W'(1) : err_q;
    sh_d       = act ? {sh_q[BYTE_W-2:0], din} : sh_q;
    phase_d    = clear ? '0 : act ? phase_q + PH_W'(1) : phase_q;
    bv_d       = act && !clear && phase_q == PH_W'(BYTE_W-1);
    byte_d     = bv_d ? sh_d : byte_q;
    lock_d     = state_d == CHECK;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seed_cnt_q <= '0;
      miss_q     <= '0;
      err_q      <= '0;
      sh_q       <= '0;
      phase_q    <= '0;
      bv_q       <= 1'b0;
      byte_q     <= '0;
      lock_q     <= 1'b0;
    end else begin
      seed_cnt_q <= seed_cnt_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      sh_q       <= sh_d;
      phase_q    <= phase_d;
      bv_q       <= bv_d;
      byte_q     <= byte_d;
      lock_q     <= lock_d;
    end
  assign lock       = lock_q;
  assign err_cnt    = err_q;
  assign byte_out   = byte_q;
  assign byte_valid = bv_q;
endmodule

// File: tb/tb_siso_prbs_checker.sv
// tb_siso_prbs_checker: randomized-gap stimulus checked against a queue-based PRBS7 reference model
module tb_siso_prbs_checker;
  localparam int LOSS = 4;
  localparam int EW   = 8;
  logic clk = 0, rst_n = 0, ena = 0, din = 0, din_valid = 0, clear = 0;
  logic lock, byte_valid;
  logic [EW-1:0] err_cnt;
  logic [7:0] byte_out;
  int n_tot = 0, n_bad = 0, pulses = 0;
  int m_mode, m_miss, m_err;
  logic [7:0] m_bout;
  logic m_bv;
  bit seedq[$], hist[$], bq[$], prbs[$];
  always #5 clk = ~clk;
  siso_prbs_checker #(.LOSS_THRESH(LOSS), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid), .clear(clear),
    .lock(lock), .err_cnt(err_cnt), .byte_out(byte_out), .byte_valid(byte_valid)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".lock"}, lock, m_mode == 2);
    chk({tag, ".err"}, err_cnt, m_err);
    chk({tag, ".bv"}, byte_valid, m_bv);
    chk({tag, ".byte"}, byte_out, m_bout);
  endtask
  task automatic mdl_reset();
    m_mode = 0; m_miss = 0; m_err = 0; m_bout = 0; m_bv = 0;
    seedq.delete(); hist.delete(); bq.delete();
  endtask
  // modes: 0 idle, 1 collecting seed bits, 2 predicting from the last seven sequence bits
  task automatic mdl(input logic e, input logic dv, input logic d, input logic c);
    logic [7:0] v, old;
    int ones;
    bit ex;
    old = m_bout;
    m_bv = 0;
    if (!e) begin
      m_mode = 0; m_miss = 0; seedq.delete();
    end else if (m_mode == 0) m_mode = 1;
    else if (dv) begin
      bq.push_back(d);
      if (bq.size() == 8) begin
        v = 0;
        foreach (bq[i]) v = {v[6:0], bq[i]};
        m_bout = v; m_bv = 1; bq.delete();
      end
      if (m_mode == 1) begin
        seedq.push_back(d);
        if (seedq.size() == 7) begin
          ones = 0;
          foreach (seedq[i]) ones += int'(seedq[i]);
          if (ones != 0) begin hist = seedq; m_mode = 2; m_miss = 0; end
          seedq.delete();
        end
      end else begin
        ex = hist[0] ^ hist[1];
        void'(hist.pop_front());
        hist.push_back(ex);
        if (d != ex) begin
          if (m_err < (1 << EW) - 1) m_err++;
          m_miss++;
          if (m_miss == LOSS) begin m_mode = 1; m_miss = 0; seedq.delete(); end
        end else m_miss = 0;
      end
    end
    if (c) begin m_err = 0; bq.delete(); m_bv = 0; m_bout = old; end
  endtask
  task automatic step(input logic e, input logic dv, input logic d, input logic c);
    ena = e; din_valid = dv; din = d; clear = c;
    mdl(e, dv, d, c);
    @(posedge clk); #1;
    check_all("step");
    if (byte_valid) pulses++;
  endtask
  task automatic send(input bit d);
    repeat ($urandom_range(0, 2)) step(1, 0, 1'($urandom_range(0, 1)), 0);
    step(1, 1, d, 0);
  endtask
  task automatic do_reset();
    rst_n = 0; ena = 0; din_valid = 0; din = 0; clear = 0;
    mdl_reset();
    @(posedge clk); #1;
    check_all("rst");
    rst_n = 1;
    step(1, 0, 0, 0);
  endtask
  task automatic gen(input int n);
    prbs.delete();
    for (int i = 0; i < n; i++) prbs.push_back(i < 7 ? 1'b1 : prbs[i-7] ^ prbs[i-6]);
  endtask
  initial begin
    int at, fall, rise, flag;
    gen(1000);
    do_reset();
    pulses = 0; at = -1;
    for (int i = 0; i < 200; i++) begin
      send(prbs[i]);
      if (lock && at < 0) at = i;
    end
    chk("clean_lock_at", at, 6);
    chk("clean_err", err_cnt, 0);
    chk("clean_bytes", pulses, 25);
    do_reset();
    flag = 0;
    for (int i = 0; i < 200; i++) begin
      send(prbs[i] ^ (i == 50));
      if (i >= 6 && !lock) flag = 1;
    end
    chk("flip_err", err_cnt, 1);
    chk("flip_lock_held", flag, 0);
    do_reset();
    fall = -1; rise = -1;
    for (int i = 0; i < 120; i++) begin
      send(prbs[i] ^ (i >= 60 && i < 64));
      if (i >= 60 && !lock && fall < 0) fall = i;
      if (fall >= 0 && rise < 0 && lock) rise = i;
    end
    chk("loss_fall", fall, 63);
    chk("loss_rise", rise, 70);
    chk("loss_err", err_cnt, 4);
    do_reset();
    flag = 0;
    for (int i = 0; i < 100; i++) begin
      send(0);
      if (lock) flag = 1;
    end
    chk("zero_lock", flag, 0);
    chk("zero_err", err_cnt, 0);
    do_reset();
    for (int i = 0; i < 907; i++) send(prbs[i] ^ (i >= 7 && (i - 7) % 3 == 0));
    chk("sat_err", err_cnt, 255);
    step(1, 1, !prbs[907], 1);
    chk("clear_wins", err_cnt, 0);
    do_reset();
    for (int i = 0; i < 11; i++) send(prbs[i]);
    rst_n = 0;
    mdl_reset();
    #1;
    chk("arst_lock", lock, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_byte", byte_out, 0);
    chk("arst_bv", byte_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    step(1, 0, 0, 0);
    at = -1;
    for (int i = 0; i < 8; i++) begin
      send(prbs[i]);
      if (byte_valid && at < 0) at = i;
    end
    chk("arst_next_byte", at, 7);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 24) == 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
